// File: rtl/cache_pkg.sv
// Shared sizes and enums for the split-cache memory subsystem.
package cache_pkg;

  localparam int unsigned LINE_W  = 64;
  localparam int unsigned LADDR_W = 14;

  typedef enum logic [1:0] {GNT_I, GNT_D, GNT_WB, GNT_WT} gnt_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority client select (wb > wt > d > i) with an icache starvation override.
module mem_arb_pick
  import cache_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic wb_req,
  input  logic wt_req,
  input  logic starve,
  output gnt_e gnt_c,
  output logic vld_c
);

  always_comb begin
    gnt_c = GNT_I;
    vld_c = i_req | d_req | wb_req | wt_req;
    if (starve && i_req) gnt_c = GNT_I;
    else if (wb_req)     gnt_c = GNT_WB;
    else if (wt_req)     gnt_c = GNT_WT;
    else if (d_req)      gnt_c = GNT_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes icache fill, dcache fill, victim writeback and write-through
// onto one line-wide memory port, one complete transaction at a time.
module mem_arbiter
  import cache_pkg::LADDR_W, cache_pkg::gnt_e, cache_pkg::state_e,
         cache_pkg::GNT_I, cache_pkg::GNT_D, cache_pkg::GNT_WB, cache_pkg::GNT_WT,
         cache_pkg::IDLE, cache_pkg::ISSUE, cache_pkg::DONE;
#(
  parameter int unsigned LINE_W     = 64,
  parameter int unsigned STARVE_MAX = 4
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [LADDR_W-1:0] i_addr,
  output logic               i_fill_vld,
  output logic [LINE_W-1:0]  i_fill_data,
  input  logic               d_req,
  input  logic [LADDR_W-1:0] d_addr,
  output logic               d_fill_vld,
  output logic [LINE_W-1:0]  d_fill_data,
  input  logic               wb_req,
  input  logic [LADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0]  wb_data,
  output logic               wb_done,
  input  logic               wt_req,
  input  logic [15:0]        wt_addr,
  input  logic [15:0]        wt_data,
  output logic               wt_done,
  output logic               m_req,
  output logic               m_we,
  output logic [LADDR_W-1:0] m_addr,
  output logic [3:0]         m_wmask,
  output logic [LINE_W-1:0]  m_wdata,
  input  logic [LINE_W-1:0]  m_rdata,
  input  logic               m_ack,
  output logic               busy
);

  localparam int unsigned CNT_W = 3;

  state_e             state_q, state_d;
  gnt_e               gnt_q, gnt_d;
  gnt_e               pick_gnt;
  logic               pick_vld;
  logic               starve;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_d;
  logic               m_req_d, m_we_d, busy_d;
  logic [LADDR_W-1:0] m_addr_d;
  logic [3:0]         m_wmask_d;
  logic [LINE_W-1:0]  m_wdata_d, i_fill_data_d, d_fill_data_d;
  logic               i_fill_vld_d, d_fill_vld_d, wb_done_d, wt_done_d;

  assign starve = (starve_cnt >= CNT_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .wb_req (wb_req),
    .wt_req (wt_req),
    .starve (starve),
    .gnt_c  (pick_gnt),
    .vld_c  (pick_vld)
  );

  // Next-state and next-output logic; every register holds unless changed here.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    starve_cnt_d  = starve_cnt;
    m_req_d       = m_req;
    m_we_d        = m_we;
    m_addr_d      = m_addr;
    m_wmask_d     = m_wmask;
    m_wdata_d     = m_wdata;
    i_fill_data_d = i_fill_data;
    d_fill_data_d = d_fill_data;
    i_fill_vld_d  = 1'b0;
    d_fill_vld_d  = 1'b0;
    wb_done_d     = 1'b0;
    wt_done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          gnt_d   = pick_gnt;
          m_req_d = 1'b1;
          unique case (pick_gnt)
            GNT_WB: begin
              m_we_d    = 1'b1;
              m_addr_d  = wb_addr;
              m_wmask_d = 4'b1111;
              m_wdata_d = wb_data;
            end
            GNT_WT: begin
              m_we_d    = 1'b1;
              m_addr_d  = wt_addr[15:2];
              m_wmask_d = 4'(4'b0001 << wt_addr[1:0]);
              m_wdata_d = LINE_W'({4{wt_data}});
            end
            GNT_D: begin
              m_we_d    = 1'b0;
              m_addr_d  = d_addr;
              m_wmask_d = 4'b0000;
            end
            default: begin
              m_we_d    = 1'b0;
              m_addr_d  = i_addr;
              m_wmask_d = 4'b0000;
            end
          endcase
          // Count only arbitrations the icache was present for and lost.
          if (!i_req || pick_gnt == GNT_I) starve_cnt_d = '0;
          else                             starve_cnt_d = starve_cnt + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (m_ack) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_wmask_d = 4'b0000;
          unique case (gnt_q)
            GNT_I: begin
              i_fill_data_d = m_rdata;
              i_fill_vld_d  = 1'b1;
            end
            GNT_D: begin
              d_fill_data_d = m_rdata;
              d_fill_vld_d  = 1'b1;
            end
            GNT_WB:  wb_done_d = 1'b1;
            default: wt_done_d = 1'b1;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      starve_cnt  <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wmask     <= '0;
      m_wdata     <= '0;
      i_fill_data <= '0;
      d_fill_data <= '0;
      i_fill_vld  <= 1'b0;
      d_fill_vld  <= 1'b0;
      wb_done     <= 1'b0;
      wt_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      starve_cnt  <= starve_cnt_d;
      m_req       <= m_req_d;
      m_we        <= m_we_d;
      m_addr      <= m_addr_d;
      m_wmask     <= m_wmask_d;
      m_wdata     <= m_wdata_d;
      i_fill_data <= i_fill_data_d;
      d_fill_data <= d_fill_data_d;
      i_fill_vld  <= i_fill_vld_d;
      d_fill_vld  <= d_fill_vld_d;
      wb_done     <= wb_done_d;
      wt_done     <= wt_done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk, rst;
  logic        req_a  [4];
  logic [15:0] addr_a [4];
  logic [63:0] data_a [4];

  logic        i_req, d_req, wb_req, wt_req;
  logic [13:0] i_addr, d_addr, wb_addr;
  logic [63:0] wb_data;
  logic [15:0] wt_addr, wt_data;
  logic        i_fill_vld, d_fill_vld, wb_done, wt_done;
  logic [63:0] i_fill_data, d_fill_data;
  logic        m_req, m_we, m_ack, busy;
  logic [13:0] m_addr;
  logic [3:0]  m_wmask;
  logic [63:0] m_wdata, m_rdata;
  logic [3:0]  pulses;

  logic        auto_ack, man_ack, auto_en;
  int          fixed_lat;
  int          wcnt;
  logic [63:0] mem [int];

  int n_chk = 0;
  int n_fail = 0;

  assign i_req   = req_a[0];
  assign d_req   = req_a[1];
  assign wb_req  = req_a[2];
  assign wt_req  = req_a[3];
  assign i_addr  = addr_a[0][13:0];
  assign d_addr  = addr_a[1][13:0];
  assign wb_addr = addr_a[2][13:0];
  assign wt_addr = addr_a[3];
  assign wb_data = data_a[2];
  assign wt_data = data_a[3][15:0];
  assign m_ack   = auto_ack | man_ack;
  assign pulses  = {i_fill_vld, d_fill_vld, wb_done, wt_done};

  mem_arbiter #(.LINE_W(64), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_fill_vld(i_fill_vld), .i_fill_data(i_fill_data),
    .d_req(d_req), .d_addr(d_addr), .d_fill_vld(d_fill_vld), .d_fill_data(d_fill_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_done(wb_done),
    .wt_req(wt_req), .wt_addr(wt_addr), .wt_data(wt_data), .wt_done(wt_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] mem_rd(int a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Memory responder: acks after the chosen latency, applies masked writes.
  initial begin
    logic [63:0] line;
    auto_ack = 1'b0;
    m_rdata  = '0;
    wcnt     = 0;
    forever begin
      @(negedge clk);
      auto_ack = 1'b0;
      if (rst || !m_req) wcnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      else if (wcnt > 0) wcnt--;
      else if (auto_en) begin
        line = mem_rd(int'(m_addr));
        if (m_we)
          for (int w = 0; w < 4; w++)
            if (m_wmask[w]) line[w*16 +: 16] = m_wdata[w*16 +: 16];
        if (m_we) mem[int'(m_addr)] = line;
        m_rdata  = line;
        auto_ack = 1'b1;
      end
    end
  end

  function automatic int ref_winner(logic [3:0] r, int cnt);
    if (r[0] && cnt >= STARVE) return 0;
    if (r[2]) return 2;
    if (r[3]) return 3;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    n_chk++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we got=%b exp=0", m_we); end
    n_chk++; if (m_wmask !== 4'h0) begin n_fail++; $display("FAIL reset_m_wmask got=%h exp=0", m_wmask); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (pulses !== 4'h0) begin n_fail++; $display("FAIL reset_pulses got=%b exp=0000", pulses); end
    n_chk++; if (m_addr !== 14'h0) begin n_fail++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
    n_chk++; if (m_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_m_wdata got=%h exp=0", m_wdata); end
    n_chk++; if (i_fill_data !== 64'h0 || d_fill_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_fill got=%h/%h exp=0/0", i_fill_data, d_fill_data); end
    n_chk++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_lone_fill();
    logic [63:0] line;
    line = 64'h0004_0003_0002_0001;
    mem[32'h40] = line;
    fixed_lat = 3;
    @(posedge clk); #1;
    req_a[0] = 1'b1; addr_a[0] = 16'h0040;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      n_chk++; if (m_req !== (c <= 4)) begin n_fail++; $display("FAIL lone_m_req cyc=%0d got=%b exp=%b", c, m_req, c <= 4); end
      if (c <= 4) begin
        n_chk++; if (m_we !== 1'b0 || m_addr !== 14'h40) begin
          n_fail++; $display("FAIL lone_cmd cyc=%0d got we=%b addr=%h exp we=0 addr=0040", c, m_we, m_addr); end
      end
      n_chk++; if (i_fill_vld !== (c == 5)) begin n_fail++; $display("FAIL lone_vld cyc=%0d got=%b exp=%b", c, i_fill_vld, c == 5); end
      n_chk++; if (busy !== (c <= 5)) begin n_fail++; $display("FAIL lone_busy cyc=%0d got=%b exp=%b", c, busy, c <= 5); end
      if (c >= 5) begin
        n_chk++; if (i_fill_data !== line) begin n_fail++; $display("FAIL lone_data cyc=%0d got=%h exp=%h", c, i_fill_data, line); end
      end
      if (i_fill_vld) req_a[0] = 1'b0;
    end
    fixed_lat = -1;
  endtask

  task automatic test_simultaneous();
    int          order[$];
    logic        prev, done;
    logic [63:0] wbd, iline;
    wbd   = {$urandom, $urandom};
    iline = 64'hA5A5_0123_4567_89AB;
    mem[32'h41] = 64'hDEAD_BEEF_DEAD_BEEF;
    mem[32'h10] = iline;
    prev = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    addr_a[0] = 16'h0010; addr_a[1] = 16'h0041; addr_a[2] = 16'h0041; data_a[2] = wbd;
    req_a[0] = 1'b1; req_a[1] = 1'b1; req_a[2] = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if (m_req && !prev) begin
        if (m_we) begin
          order.push_back(2);
          n_chk++; if (m_wmask !== 4'hF || m_wdata !== wbd) begin
            n_fail++; $display("FAIL sim_wb_cmd got mask=%h data=%h exp mask=f data=%h", m_wmask, m_wdata, wbd); end
        end else order.push_back(m_addr == 14'h41 ? 1 : 0);
      end
      prev = m_req;
      if (wb_done) req_a[2] = 1'b0;
      if (d_fill_vld) begin
        n_chk++; if (d_fill_data !== wbd) begin n_fail++; $display("FAIL sim_d_data got=%h exp=%h", d_fill_data, wbd); end
        req_a[1] = 1'b0;
      end
      if (i_fill_vld) begin
        n_chk++; if (i_fill_data !== iline) begin n_fail++; $display("FAIL sim_i_data got=%h exp=%h", i_fill_data, iline); end
        req_a[0] = 1'b0;
        done = 1'b1;
      end
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL sim_timeout got=incomplete exp=three completions"); end
    n_chk++; if (order.size() != 3 || order[0] != 2 || order[1] != 1 || order[2] != 0) begin
      n_fail++; $display("FAIL sim_order got=%p exp='{2,1,0}", order); end
    req_a[0] = 1'b0; req_a[1] = 1'b0; req_a[2] = 1'b0;
  endtask

  task automatic test_write_through();
    int   ndone;
    logic prev;
    ndone = 0; prev = 1'b0;
    mem[0] = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    addr_a[3] = 16'h0002; data_a[3] = 64'h0000_0000_0000_FFFE; req_a[3] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_req && !prev) begin
        n_chk++; if (m_we !== 1'b1 || m_addr !== 14'h0 || m_wmask !== 4'b0100) begin
          n_fail++; $display("FAIL wt_cmd got we=%b addr=%h mask=%b exp we=1 addr=0 mask=0100", m_we, m_addr, m_wmask); end
        n_chk++; if (m_wdata[47:32] !== 16'hFFFE) begin n_fail++; $display("FAIL wt_lane got=%h exp=fffe", m_wdata[47:32]); end
      end
      prev = m_req;
      if (wt_done) begin ndone++; req_a[3] = 1'b0; end
    end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL wt_done_count got=%0d exp=1", ndone); end
    n_chk++; if (mem_rd(0) !== 64'h1111_FFFE_3333_4444) begin
      n_fail++; $display("FAIL wt_mem got=%h exp=1111fffe33334444", mem_rd(0)); end
  endtask

  task automatic test_starvation();
    int   ngr, i_idx;
    logic prev, rearm_wb, rearm_d, done;
    ngr = 0; i_idx = -1; prev = 1'b0; rearm_wb = 1'b0; rearm_d = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    addr_a[0] = 16'h0100; addr_a[1] = 16'h0300; addr_a[2] = 16'h0200; data_a[2] = {$urandom, $urandom};
    req_a[0] = 1'b1; req_a[1] = 1'b1; req_a[2] = 1'b1;
    for (int c = 0; c < 120 && !done; c++) begin
      @(posedge clk); #1;
      if (m_req && !prev) begin
        ngr++;
        if (m_addr == 14'h100) begin
          i_idx = ngr;
          n_chk++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt); end
        end else begin
          n_chk++; if (dut.starve_cnt !== 3'(ngr)) begin n_fail++; $display("FAIL starve_cnt grant=%0d got=%0d exp=%0d", ngr, dut.starve_cnt, ngr); end
        end
      end
      prev = m_req;
      if (rearm_wb) begin req_a[2] = 1'b1; rearm_wb = 1'b0; end
      if (rearm_d)  begin req_a[1] = 1'b1; rearm_d = 1'b0; end
      if (wb_done)    begin req_a[2] = 1'b0; rearm_wb = 1'b1; end
      if (d_fill_vld) begin req_a[1] = 1'b0; rearm_d = 1'b1; end
      if (i_fill_vld) begin req_a[0] = 1'b0; req_a[1] = 1'b0; req_a[2] = 1'b0; done = 1'b1; end
    end
    n_chk++; if (i_idx != STARVE + 1) begin n_fail++; $display("FAIL starve_grant got=%0d exp=%0d", i_idx, STARVE + 1); end
    @(posedge clk); #1;
    n_chk++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL starve_final got=%0d exp=0", dut.starve_cnt); end
    req_a[0] = 1'b0; req_a[1] = 1'b0; req_a[2] = 1'b0;
  endtask

  task automatic test_stray_ack();
    auto_en = 1'b0;
    @(posedge clk); #1;
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (busy !== 1'b0 || m_req !== 1'b0 || pulses !== 4'h0) begin
        n_fail++; $display("FAIL stray_ack cyc=%0d got busy=%b m_req=%b pulses=%b exp 0/0/0000", c, busy, m_req, pulses); end
      @(posedge clk); #1;
    end
    auto_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic        seen, got;
    logic [63:0] line;
    line = 64'h5555_AAAA_1234_4321;
    mem[32'h55] = line;
    seen = 1'b0; got = 1'b0;
    auto_en = 1'b0;
    @(posedge clk); #1;
    addr_a[0] = 16'h0055; req_a[0] = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      seen = m_req;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rmid_issue got m_req=0 exp=1 within 10 cycles"); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_chk++; if (m_req !== 1'b0 || m_we !== 1'b0 || m_wmask !== 4'h0 || busy !== 1'b0 || pulses !== 4'h0) begin
      n_fail++; $display("FAIL rmid_outputs got m_req=%b we=%b mask=%h busy=%b pulses=%b exp all 0", m_req, m_we, m_wmask, busy, pulses); end
    n_chk++; if (m_addr !== 14'h0 || m_wdata !== 64'h0 || i_fill_data !== 64'h0) begin
      n_fail++; $display("FAIL rmid_regs got addr=%h wdata=%h fill=%h exp 0", m_addr, m_wdata, i_fill_data); end
    req_a[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_chk++; if (pulses !== 4'h0 || busy !== 1'b0 || m_req !== 1'b0) begin
        n_fail++; $display("FAIL rmid_late_ack cyc=%0d got pulses=%b busy=%b m_req=%b exp 0", c, pulses, busy, m_req); end
      @(posedge clk); #1;
    end
    auto_en = 1'b1; fixed_lat = 1;
    req_a[0] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (i_fill_vld) begin
        got = 1'b1;
        req_a[0] = 1'b0;
        n_chk++; if (i_fill_data !== line) begin n_fail++; $display("FAIL rmid_refill got=%h exp=%h", i_fill_data, line); end
      end
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL rmid_refill_timeout got=no pulse exp=i_fill_vld"); end
    req_a[0] = 1'b0; fixed_lat = -1;
  endtask

  // Randomized traffic; the model tracks phase, winner and starvation from the arbitration rules.
  task automatic test_random();
    int          mphase, mg, mcnt, w;
    logic [3:0]  rv;
    logic        e_we;
    logic [13:0] e_addr;
    logic [3:0]  e_mask;
    logic [63:0] e_wdata, exp_i, exp_d;
    logic        granted;
    mphase = 0; mg = 0; mcnt = 0; exp_i = '0; exp_d = '0;
    e_we = 1'b0; e_addr = '0; e_mask = '0; e_wdata = '0;
    for (int c = 0; c < 4; c++) req_a[c] = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      rv = {req_a[3], req_a[2], req_a[1], req_a[0]};
      case (mphase)
        0: begin
          w = ref_winner(rv, mcnt);
          if (w >= 0) begin
            if (!rv[0] || w == 0) mcnt = 0; else mcnt++;
            mg = w; mphase = 1;
            case (w)
              0: begin e_we = 1'b0; e_addr = addr_a[0][13:0]; e_mask = 4'h0; end
              1: begin e_we = 1'b0; e_addr = addr_a[1][13:0]; e_mask = 4'h0; end
              2: begin e_we = 1'b1; e_addr = addr_a[2][13:0]; e_mask = 4'hF; e_wdata = data_a[2]; end
              default: begin
                e_we = 1'b1; e_addr = addr_a[3][15:2];
                e_mask = 4'b0001 << addr_a[3][1:0];
                e_wdata = {4{data_a[3][15:0]}};
              end
            endcase
          end
        end
        1: if (m_ack) begin
          mphase = 2;
          if (mg == 0) exp_i = m_rdata;
          if (mg == 1) exp_d = m_rdata;
        end
        default: mphase = 0;
      endcase
      n_chk++; if (m_req !== (mphase == 1) || busy !== (mphase != 0)) begin
        n_fail++; $display("FAIL rnd_phase cyc=%0d got m_req=%b busy=%b exp phase=%0d", cyc, m_req, busy, mphase); end
      if (mphase == 1) begin
        n_chk++; if (m_we !== e_we || m_addr !== e_addr || m_wmask !== e_mask) begin
          n_fail++; $display("FAIL rnd_cmd cyc=%0d got we=%b addr=%h mask=%b exp we=%b addr=%h mask=%b client=%0d",
                             cyc, m_we, m_addr, m_wmask, e_we, e_addr, e_mask, mg); end
        if (e_we) begin
          n_chk++; if (m_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, m_wdata, e_wdata); end
        end
      end
      n_chk++; if (pulses !== ((mphase == 2) ? (4'b1000 >> ((mg == 0) ? 0 : (mg == 1) ? 1 : (mg == 2) ? 2 : 3)) : 4'b0000)) begin
        n_fail++; $display("FAIL rnd_pulse cyc=%0d got=%b client=%0d phase=%0d", cyc, pulses, mg, mphase); end
      n_chk++; if (i_fill_data !== exp_i || d_fill_data !== exp_d) begin
        n_fail++; $display("FAIL rnd_fill cyc=%0d got=%h/%h exp=%h/%h", cyc, i_fill_data, d_fill_data, exp_i, exp_d); end
      n_chk++; if (dut.starve_cnt !== 3'(mcnt)) begin
        n_fail++; $display("FAIL rnd_starve cyc=%0d got=%0d exp=%0d", cyc, dut.starve_cnt, mcnt); end
      if (mphase == 2) req_a[mg] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        granted = (mphase != 0) && (mg == k);
        if (!req_a[k] && !granted) begin
          if ($urandom_range(0, 2) == 0) begin
            req_a[k]  = 1'b1;
            addr_a[k] = (k == 3) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 7));
            data_a[k] = {$urandom, $urandom};
          end
        end else if (req_a[k] && !granted && $urandom_range(0, 31) == 0) begin
          req_a[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) req_a[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; man_ack = 1'b0; auto_en = 1'b1; fixed_lat = -1;
    for (int k = 0; k < 4; k++) begin
      req_a[k] = 1'b0; addr_a[k] = '0; data_a[k] = '0;
    end
    test_reset();
    test_lone_fill();
    test_simultaneous();
    test_write_through();
    test_starvation();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
